// File: rtl/encode_pkg.sv
// Shared definitions for the PS/2-to-encoder sequencer: scan-code constants,
// the letter table, the controller state type and the scan-to-ASCII lookup.
package encode_pkg;

  localparam logic [7:0] SCAN_BREAK  = 8'hF0;
  localparam logic [7:0] SCAN_EXT    = 8'hE0;
  localparam logic [7:0] ASCII_BASE  = 8'h41;
  localparam int         NUM_LETTERS = 26;

  // Set-2 make codes, element 0 is 'A' and element 25 is 'Z'
  localparam logic [NUM_LETTERS-1:0][7:0] LETTER_CODES = {
    8'h1A, 8'h35, 8'h22, 8'h1D, 8'h2A, 8'h3C, 8'h2C, 8'h1B, 8'h2D,
    8'h15, 8'h4D, 8'h44, 8'h31, 8'h3A, 8'h4B, 8'h42, 8'h3B, 8'h43,
    8'h33, 8'h34, 8'h2B, 8'h24, 8'h23, 8'h21, 8'h32, 8'h1C
  };

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Returns {hit, ascii}; hit is low for anything that is not a letter key
  function automatic logic [8:0] scan_to_ascii(input logic [7:0] code);
    logic [8:0] result;
    result = '0;
    for (int i = 0; i < NUM_LETTERS; i++) begin
      if (LETTER_CODES[i] == code) result = {1'b1, ASCII_BASE + 8'(i)};
    end
    return result;
  endfunction

endpackage

// File: rtl/encode_fifo.sv
// Small synchronous character queue with occupancy count. A write on a full
// queue is accepted only when a read happens in the same cycle.
module encode_fifo
  import encode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     write_en,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     read_en,
  output logic [WIDTH-1:0]         read_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] write_ptr;
  logic [PTR_W-1:0] read_ptr;
  logic             do_write;
  logic             do_read;

  assign do_read   = read_en && (count != '0);
  assign do_write  = write_en && (!full || do_read);
  assign full      = (count == CNT_W'(DEPTH));
  assign read_data = mem[read_ptr];

  // Storage array; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (do_write) mem[write_ptr] <= write_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_ptr <= '0;
      read_ptr  <= '0;
      count     <= '0;
    end else begin
      if (do_write) write_ptr <= write_ptr + 1'b1;
      if (do_read)  read_ptr  <= read_ptr + 1'b1;
      if (do_write && !do_read)      count <= count + 1'b1;
      else if (!do_write && do_read) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/encode_sequencer.sv
// Filters PS/2 scan codes down to letter keys, queues them as ASCII and
// hands them one at a time to an external encoder, collecting its result.
// Optional WAIT timeout is built when ENCODE_SEQ_TIMEOUT_EN is defined.
module encode_sequencer
  import encode_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [7:0]                    i_scan_data,
  input  logic                          i_scan_en,
  input  logic                          i_enc_ready,
  input  logic [7:0]                    i_enc_data,
  input  logic                          i_enc_valid,
  output logic                          o_enc_start,
  output logic [7:0]                    o_enc_data,
  output logic [4:0]                    o_char,
  output logic                          o_char_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_busy,
  output logic                          o_overflow,
  output logic                          o_timeout
);

  state_t     state;
  logic       break_pending;
  logic       ext_pending;
  logic [8:0] lookup;
  logic       is_prefix;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic [7:0] fifo_head;
  logic [2:0] unused_enc_bits;

  assign unused_enc_bits = i_enc_data[7:5];
  assign lookup          = scan_to_ascii(i_scan_data);
  assign is_prefix       = (i_scan_data == SCAN_BREAK) || (i_scan_data == SCAN_EXT);
  assign push            = i_scan_en && !is_prefix && !break_pending && !ext_pending && lookup[8];
  assign pop             = (state == ISSUE);

`ifdef ENCODE_SEQ_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TIMER_W-1:0] timer;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign o_timeout = 1'b0;
`endif

  encode_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk        (CLOCK_50),
    .rst        (reset),
    .write_en   (push),
    .write_data (lookup[7:0]),
    .read_en    (pop),
    .read_data  (fifo_head),
    .count      (o_fifo_count),
    .full       (fifo_full)
  );

  // Prefix tracking: a break or extended prefix swallows the following byte
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
    end else if (i_scan_en) begin
      if (i_scan_data == SCAN_BREAK) begin
        break_pending <= 1'b1;
      end else if (i_scan_data == SCAN_EXT) begin
        ext_pending <= 1'b1;
      end else begin
        break_pending <= 1'b0;
        ext_pending   <= 1'b0;
      end
    end
  end

  // Sticky drop flag; a full queue still accepts a push when it pops too
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      o_overflow <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      o_overflow <= 1'b1;
    end
  end

  // Controller: issue queue head, wait for the encoder, report the result
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      o_enc_start  <= 1'b0;
      o_enc_data   <= '0;
      o_char       <= '0;
      o_char_valid <= 1'b0;
      o_busy       <= 1'b0;
`ifdef ENCODE_SEQ_TIMEOUT_EN
      o_timeout    <= 1'b0;
      timer        <= '0;
`endif
    end else begin
      o_enc_start  <= 1'b0;
      o_char_valid <= 1'b0;
`ifdef ENCODE_SEQ_TIMEOUT_EN
      o_timeout    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if ((o_fifo_count != '0) && i_enc_ready) begin
            state       <= ISSUE;
            o_enc_start <= 1'b1;
            o_enc_data  <= fifo_head;
            o_busy      <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef ENCODE_SEQ_TIMEOUT_EN
          timer <= '0;
`endif
        end
        WAIT: begin
          if (i_enc_valid) begin
            state        <= DONE;
            o_char       <= i_enc_data[4:0];
            o_char_valid <= 1'b1;
            o_busy       <= 1'b0;
          end
`ifdef ENCODE_SEQ_TIMEOUT_EN
          else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_timeout <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_encode_sequencer.sv
// Testbench for encode_sequencer: directed scenarios followed by a randomized
// scan-code stream checked against a queue-based reference model.
module tb_encode_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] i_scan_data;
  logic       i_scan_en;
  logic       i_enc_ready;
  logic [7:0] i_enc_data;
  logic       i_enc_valid;
  logic       o_enc_start;
  logic [7:0] o_enc_data;
  logic [4:0] o_char;
  logic       o_char_valid;
  logic [2:0] o_fifo_count;
  logic       o_busy;
  logic       o_overflow;
  logic       o_timeout;

  int total_checks  = 0;
  int passed_checks = 0;
  int failed_checks = 0;

  // Letter make codes in alphabetical order, kept independent of the design
  localparam logic [7:0] LETTER_SCAN [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
  };

  // Reference model state for the randomized phase
  logic [7:0] model_q [$];
  logic [4:0] exp_chars [$];
  bit         model_ovf;
  bit         model_break;
  bit         model_ext;

  encode_sequencer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .i_scan_data  (i_scan_data),
    .i_scan_en    (i_scan_en),
    .i_enc_ready  (i_enc_ready),
    .i_enc_data   (i_enc_data),
    .i_enc_valid  (i_enc_valid),
    .o_enc_start  (o_enc_start),
    .o_enc_data   (o_enc_data),
    .o_char       (o_char),
    .o_char_valid (o_char_valid),
    .o_fifo_count (o_fifo_count),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow),
    .o_timeout    (o_timeout)
  );

  // Free-running clock
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic int letter_index(input logic [7:0] code);
    for (int i = 0; i < 26; i++) begin
      if (LETTER_SCAN[i] == code) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) passed_checks++;
    else begin
      failed_checks++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] code);
    i_scan_data = code;
    i_scan_en   = 1'b1;
    tick();
    i_scan_en   = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_start"},   32'(o_enc_start),  0);
    checkOutput({tag, "_encdata"}, 32'(o_enc_data),   0);
    checkOutput({tag, "_char"},    32'(o_char),       0);
    checkOutput({tag, "_cvalid"},  32'(o_char_valid), 0);
    checkOutput({tag, "_busy"},    32'(o_busy),       0);
    checkOutput({tag, "_ovf"},     32'(o_overflow),   0);
    checkOutput({tag, "_tmo"},     32'(o_timeout),    0);
    checkOutput({tag, "_count"},   32'(o_fifo_count), 0);
  endtask

  task automatic waitForStart(input string tag);
    int n;
    n = 0;
    while (o_enc_start !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(o_enc_start), 1);
  endtask

  task automatic serveOne(input logic [7:0] exp_ascii, input logic [4:0] reply);
    waitForStart("serve_start");
    checkOutput("serve_encdata", 32'(o_enc_data), 32'(exp_ascii));
    tick();
    i_enc_valid = 1'b1;
    i_enc_data  = {3'b101, reply};
    tick();
    i_enc_valid = 1'b0;
    checkOutput("serve_cvalid", 32'(o_char_valid), 1);
    checkOutput("serve_char",   32'(o_char), 32'(reply));
  endtask

  task automatic resetDut();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int         n;
    bit         seen_flag;
    bit         pop_now;
    bit         armed;
    int         delay_cnt;
    int         idx;
    int         issued;
    int         received;
    logic [4:0] reply_idx;
    logic [7:0] exp_head;
    logic [7:0] code;

    reset       = 1'b1;
    i_scan_data = 8'h00;
    i_scan_en   = 1'b0;
    i_enc_ready = 1'b0;
    i_enc_data  = 8'h00;
    i_enc_valid = 1'b0;
    tick();
    tick();
    $display("[TB] reset state");
    checkAllZero("reset");
    reset = 1'b0;
    tick();

    $display("[TB] single letter round trip");
    i_enc_ready = 1'b1;
    applyStimulus(8'h1C);
    checkOutput("a_count_next",  32'(o_fifo_count), 1);
    checkOutput("a_start_early", 32'(o_enc_start),  0);
    tick();
    checkOutput("a_start_2cyc", 32'(o_enc_start), 1);
    checkOutput("a_encdata",    32'(o_enc_data),  32'h41);
    checkOutput("a_busy_issue", 32'(o_busy),      1);
    tick();
    checkOutput("a_start_pulse", 32'(o_enc_start),  0);
    checkOutput("a_busy_wait",   32'(o_busy),       1);
    checkOutput("a_encdata_hold",32'(o_enc_data),   32'h41);
    checkOutput("a_count_pop",   32'(o_fifo_count), 0);
    i_enc_valid = 1'b1;
    i_enc_data  = 8'd7;
    tick();
    i_enc_valid = 1'b0;
    checkOutput("a_char",      32'(o_char),       7);
    checkOutput("a_cvalid",    32'(o_char_valid), 1);
    checkOutput("a_busy_done", 32'(o_busy),       0);
    tick();
    checkOutput("a_cvalid_pulse", 32'(o_char_valid), 0);

    $display("[TB] stray encoder result in IDLE");
    i_enc_valid = 1'b1;
    i_enc_data  = 8'd9;
    tick();
    i_enc_valid = 1'b0;
    checkOutput("stray_char",   32'(o_char),       7);
    checkOutput("stray_cvalid", 32'(o_char_valid), 0);

    $display("[TB] prefix filtering");
    i_enc_ready = 1'b0;
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    checkOutput("break_count", 32'(o_fifo_count), 0);
    applyStimulus(8'hE0);
    applyStimulus(8'h32);
    checkOutput("ext_count", 32'(o_fifo_count), 0);
    applyStimulus(8'h16);
    tick();
    checkOutput("nonletter_count", 32'(o_fifo_count), 0);

    $display("[TB] overflow then drain in order");
    applyStimulus(8'h1C);
    applyStimulus(8'h32);
    applyStimulus(8'h21);
    applyStimulus(8'h23);
    checkOutput("fill_count", 32'(o_fifo_count), 4);
    checkOutput("fill_ovf",   32'(o_overflow),   0);
    applyStimulus(8'h24);
    checkOutput("ovf_count", 32'(o_fifo_count), 4);
    checkOutput("ovf_flag",  32'(o_overflow),   1);
    i_enc_ready = 1'b1;
    serveOne(8'h41, 5'd0);
    serveOne(8'h42, 5'd1);
    serveOne(8'h43, 5'd2);
    serveOne(8'h44, 5'd3);
    tick();
    tick();
    tick();
    checkOutput("drain_count",  32'(o_fifo_count), 0);
    checkOutput("drain_start",  32'(o_enc_start),  0);
    checkOutput("ovf_sticky",   32'(o_overflow),   1);

    $display("[TB] reset during WAIT");
    i_enc_ready = 1'b0;
    applyStimulus(8'h1C);
    applyStimulus(8'h32);
    applyStimulus(8'h21);
    i_enc_ready = 1'b1;
    waitForStart("rw_start");
    tick();
    checkOutput("rw_count_wait", 32'(o_fifo_count), 2);
    checkOutput("rw_busy_wait",  32'(o_busy),       1);
    reset = 1'b1;
    #1;
    checkAllZero("rw_async");
    tick();
    reset = 1'b0;
    i_enc_valid = 1'b1;
    i_enc_data  = 8'd5;
    tick();
    i_enc_valid = 1'b0;
    checkOutput("rw_cvalid", 32'(o_char_valid), 0);
    checkOutput("rw_char",   32'(o_char),       0);
    checkOutput("rw_count",  32'(o_fifo_count), 0);
    checkOutput("rw_busy",   32'(o_busy),       0);
    tick();
    checkOutput("rw_nostart", 32'(o_enc_start), 0);

    $display("[TB] push and pop together on a full queue");
    i_enc_ready = 1'b0;
    applyStimulus(8'h1C);
    applyStimulus(8'h32);
    applyStimulus(8'h21);
    applyStimulus(8'h23);
    checkOutput("pp_fill",     32'(o_fifo_count), 4);
    checkOutput("pp_ovf_pre",  32'(o_overflow),   0);
    i_enc_ready = 1'b1;
    tick();
    checkOutput("pp_issue",    32'(o_enc_start), 1);
    checkOutput("pp_issue_A",  32'(o_enc_data),  32'h41);
    applyStimulus(8'h24);
    checkOutput("pp_count",    32'(o_fifo_count), 4);
    checkOutput("pp_ovf",      32'(o_overflow),   0);
    i_enc_valid = 1'b1;
    i_enc_data  = 8'd0;
    tick();
    i_enc_valid = 1'b0;
    checkOutput("pp_cvalid_A", 32'(o_char_valid), 1);
    serveOne(8'h42, 5'd11);
    serveOne(8'h43, 5'd12);
    serveOne(8'h44, 5'd13);
    serveOne(8'h45, 5'd25);
    checkOutput("pp_count_end", 32'(o_fifo_count), 0);

    $display("[TB] WAIT with a silent encoder");
    applyStimulus(8'h1C);
    waitForStart("to_start");
`ifdef ENCODE_SEQ_TIMEOUT_EN
    n = 0;
    seen_flag = 1'b0;
    while (o_timeout !== 1'b1 && n < 1100) begin
      tick();
      n++;
      if (o_char_valid === 1'b1) seen_flag = 1'b1;
    end
    checkOutput("to_cycles",   32'(n),         1025);
    checkOutput("to_busy",     32'(o_busy),    0);
    checkOutput("to_nocvalid", 32'(seen_flag), 0);
    tick();
    checkOutput("to_pulse",    32'(o_timeout), 0);
    checkOutput("to_idle",     32'(o_enc_start), 0);
`else
    seen_flag = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (o_timeout !== 1'b0) seen_flag = 1'b1;
    end
    checkOutput("nto_flag", 32'(seen_flag), 0);
    checkOutput("nto_busy", 32'(o_busy),    1);
    i_enc_valid = 1'b1;
    i_enc_data  = 8'd3;
    tick();
    i_enc_valid = 1'b0;
    checkOutput("nto_cvalid", 32'(o_char_valid), 1);
    checkOutput("nto_char",   32'(o_char),       3);
`endif

    $display("[TB] randomized stream against reference model");
    resetDut();
    model_q.delete();
    exp_chars.delete();
    model_ovf   = 1'b0;
    model_break = 1'b0;
    model_ext   = 1'b0;
    armed       = 1'b0;
    delay_cnt   = 0;
    reply_idx   = '0;
    issued      = 0;
    received    = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      bit stim_on;
      stim_on = (cyc < 700);
      checkOutput("rand_count", 32'(o_fifo_count), 32'(model_q.size()));
      checkOutput("rand_ovf",   32'(o_overflow),   32'(model_ovf));
      pop_now = 1'b0;
      if (o_enc_start === 1'b1) begin
        exp_head = (model_q.size() != 0) ? model_q[0] : 8'hxx;
        checkOutput("rand_encdata", 32'(o_enc_data), 32'(exp_head));
        pop_now   = 1'b1;
        armed     = 1'b1;
        delay_cnt = $urandom_range(1, 4);
        reply_idx = 5'($urandom_range(0, 25));
        issued++;
      end
      if (o_char_valid === 1'b1) begin
        exp_head = (exp_chars.size() != 0) ? {3'b000, exp_chars[0]} : 8'hxx;
        checkOutput("rand_char", 32'(o_char), 32'(exp_head));
        if (exp_chars.size() != 0) exp_chars.delete(0);
        received++;
      end

      i_enc_valid = 1'b0;
      if (armed) begin
        if (delay_cnt == 0) begin
          i_enc_valid = 1'b1;
          i_enc_data  = {3'($urandom), reply_idx};
          exp_chars.push_back(reply_idx);
          armed = 1'b0;
        end else begin
          delay_cnt--;
        end
      end
      i_enc_ready = stim_on ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_scan_en   = stim_on && ($urandom_range(0, 99) < 45);
      n = $urandom_range(0, 99);
      if (n < 55)      code = LETTER_SCAN[$urandom_range(0, 25)];
      else if (n < 70) code = 8'hF0;
      else if (n < 80) code = 8'hE0;
      else             code = 8'($urandom);
      i_scan_data = code;
      tick();

      if (pop_now && model_q.size() != 0) model_q.delete(0);
      if (i_scan_en) begin
        if (code == 8'hF0) begin
          model_break = 1'b1;
        end else if (code == 8'hE0) begin
          model_ext = 1'b1;
        end else if (model_break || model_ext) begin
          model_break = 1'b0;
          model_ext   = 1'b0;
        end else begin
          idx = letter_index(code);
          if (idx >= 0) begin
            if (model_q.size() < 4) model_q.push_back(8'h41 + 8'(idx));
            else                    model_ovf = 1'b1;
          end
        end
      end
    end
    i_scan_en = 1'b0;
    checkOutput("rand_end_model_q", 32'(model_q.size()), 0);
    checkOutput("rand_end_count",   32'(o_fifo_count),   0);
    checkOutput("rand_end_chars",   32'(received),       32'(issued));

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/encode_sequencer.md
ENCODE_SEQUENCER -- requirements
Module: encode_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, character queue depth; power of two, at least 2.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, maximum cycles spent waiting for an encoder result.
REQ-003 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 i_scan_data  in  8  PS/2 scan code byte from the keyboard controller.
REQ-006 i_scan_en  in  1  one-cycle strobe; i_scan_data is valid.
REQ-007 i_enc_ready  in  1  encoder can accept a character.
REQ-008 i_enc_data  in  8  encoder result, letter index 0..25.
REQ-009 i_enc_valid  in  1  one-cycle strobe; i_enc_data is valid.
REQ-010 o_enc_start  out  1  one-cycle strobe to the encoder; o_enc_data is valid.
REQ-011 o_enc_data  out  8  uppercase ASCII character, 0x41..0x5A.
REQ-012 o_char  out  5  last encoded letter index.
REQ-013 o_char_valid  out  1  one-cycle strobe; o_char has been updated.
REQ-014 o_fifo_count  out  $clog2(FIFO_DEPTH)+1  queue occupancy.
REQ-015 o_busy  out  1  high in the ISSUE and WAIT states.
REQ-016 o_overflow  out  1  sticky flag: a letter was dropped.
REQ-017 o_timeout  out  1  one-cycle strobe; a WAIT timed out.

Function
REQ-018 The scan filter shall handle prefix bytes on i_scan_en: 0xF0 sets break_pending; 0xE0 sets ext_pending; neither prefix is queued.
REQ-019 Any non-prefix byte received while break_pending or ext_pending shall be discarded, and both flags shall clear.
REQ-020 A non-prefix byte with both flags clear shall go to the letter table. Letter codes (A=0x1C, B=0x32, C=0x21, ... Z=0x1A) shall push ASCII 'A'..'Z'. All other codes shall be discarded.
REQ-021 A push shall be written at the end of the strobe cycle; o_fifo_count updates on the next cycle.
REQ-022 A push with the queue full and no pop in the same cycle shall be dropped and shall set o_overflow.
REQ-023 A push and a pop in the same cycle with the queue full shall both succeed, leaving the count unchanged.
REQ-024 The controller FSM shall have four states: IDLE, ISSUE, WAIT, DONE.
REQ-025 IDLE -> ISSUE when o_fifo_count != 0 and i_enc_ready = 1.
REQ-026 ISSUE lasts exactly one cycle: o_enc_start = 1, o_enc_data = queue head, queue popped; then -> WAIT.
REQ-027 In WAIT, i_enc_valid shall capture i_enc_data[4:0] into o_char, then -> DONE.
REQ-028 i_enc_valid outside WAIT shall be ignored.
REQ-029 DONE lasts exactly one cycle: o_char_valid = 1; then -> IDLE.
REQ-030 Minimum latency from an i_scan_en letter strobe to o_enc_start is 2 cycles (queue empty, state IDLE, ready high).
REQ-031 o_enc_data shall hold its last value outside ISSUE.
REQ-032 The FIFO read and write pointers shall wrap modulo FIFO_DEPTH.

Reset
REQ-033 Reset shall, asynchronously: set the FSM to IDLE; empty the queue; clear break_pending, ext_pending and the timeout counter.
REQ-034 Reset shall drive these outputs to 0: o_enc_start, o_enc_data, o_char, o_char_valid, o_busy, o_overflow, o_timeout, o_fifo_count.
REQ-035 A reset during WAIT shall abandon the in-flight character with no o_char_valid; the encoder result arriving after release shall be ignored.

Configuration
REQ-036 Macro ENCODE_SEQ_TIMEOUT_EN controls the WAIT timeout.
REQ-037 With ENCODE_SEQ_TIMEOUT_EN defined: a counter clears on entry to WAIT and increments each WAIT cycle. On reaching TIMEOUT_CYCLES without i_enc_valid, the FSM goes WAIT -> IDLE, pulses o_timeout for one cycle, and drops the character.
REQ-038 With ENCODE_SEQ_TIMEOUT_EN undefined: WAIT persists until i_enc_valid, no counter is built, and o_timeout is tied to 0.

Structure
REQ-039 Shared package encode_pkg shall hold: the scan-code constants (0xF0, 0xE0, the 26 letter codes); the scan-to-ASCII function; the FSM state enum; the ASCII base 0x41.
REQ-040 The queue shall be the sub-module encode_fifo: synchronous write and read, count output, DEPTH parameter, asynchronous reset.

Verification
REQ-041 Scenario: i_scan_data 0x1C strobed, i_enc_ready=1 -> o_enc_start 2 cycles later with o_enc_data=0x41. Then i_enc_valid with i_enc_data=7 -> o_char=7 and o_char_valid pulse one cycle later.
REQ-042 Scenario: strobe sequence 0xF0, 0x1C -> no push; o_fifo_count stays 0. Strobe sequence 0xE0, 0x32 -> no push.
REQ-043 Scenario: i_enc_ready=0; strobe 0x1C, 0x32, 0x21, 0x23, 0x24 -> o_fifo_count=4, o_overflow=1. Raise i_enc_ready -> o_enc_data sequence 0x41, 0x42, 0x43, 0x44.
REQ-044 Scenario: ENCODE_SEQ_TIMEOUT_EN defined; issue 'A' and withhold i_enc_valid -> o_timeout pulse after 1024 WAIT cycles, FSM back in IDLE, no o_char_valid.
REQ-045 Scenario: assert reset mid-WAIT with 2 letters queued -> all outputs 0 immediately. After release, an i_enc_valid is ignored and o_fifo_count=0.
REQ-046 Scenario: queue full; strobe a letter in the same cycle as ISSUE -> o_fifo_count stays 4, o_overflow stays 0.
